isp_program_loader: RTL and testbench

- Byte-stream in-system programming (ISP) loader that sits directly upstream of RISC_V_Core.
- Receives a framed program image, assembles 32-bit little-endian words and drives the core's isp_write/isp_address/isp_data ports.
- Holds the core in reset while loading, then pulses start with prog_address.
- Replaces $readmemh preloading for hardware bring-up; instruction-test benches can use it in place of preloading.

---
 rtl/isp_pkg.sv | 24 ++
 rtl/isp_word_assembler.sv | 41 ++++
 rtl/isp_program_loader.sv | 155 +++++++++++++++
 tb/tb_isp_program_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared types and constants for the ISP program loader.
package isp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        START  = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
    localparam int unsigned LEN_BITS       = 16;
    localparam int unsigned PROG_ADDR_BITS = 20;

    // States in which the inter-byte timeout is armed.
    function automatic logic in_frame(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/isp_word_assembler.sv
// Packs data bytes LSB-first into a word and keeps a running XOR of every byte.
module isp_word_assembler #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word_c,
    output logic                  word_ready_c,
    output logic [7:0]            xor_sum
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(BYTES);

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shreg;

    // The word including the byte arriving this cycle, so the top can strobe on the next edge.
    assign word_c       = {byte_in, shreg[DATA_WIDTH-1:8]};
    assign word_ready_c = byte_valid && (idx == IDX_W'(BYTES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            shreg   <= '0;
            xor_sum <= '0;
        end else if (clear) begin
            idx     <= '0;
            shreg   <= '0;
            xor_sum <= '0;
        end else if (byte_valid) begin
            idx     <= idx + IDX_W'(1);
            shreg   <= word_c;
            xor_sum <= xor_sum ^ byte_in;
        end
    end

endmodule

// File: rtl/isp_program_loader.sv
// Framed byte-stream loader: writes program words into core memory, then starts the core.
module isp_program_loader
    import isp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_BITS   = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      isp_write,
    output logic [ADDRESS_BITS-1:0]   isp_address,
    output logic [DATA_WIDTH-1:0]     isp_data,
    output logic                      core_reset,
    output logic                      start,
    output logic [PROG_ADDR_BITS-1:0] prog_address,
    output logic                      busy,
    output logic                      error,
    output logic [LEN_BITS-1:0]       words_loaded
);

    localparam int unsigned MAX_WORDS = 2 ** ADDRESS_BITS;
    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state, state_next;
    logic [LEN_BITS-1:0]     len, len_next;
    logic [ADDRESS_BITS-1:0] word_addr, word_addr_next;
    logic [TW-1:0]           tcount, tcount_next;
    logic [LEN_BITS-1:0]     words_next;
    logic [LEN_BITS-1:0]     n_c;
    logic                    write_next;
    logic [ADDRESS_BITS-1:0] isp_address_next;
    logic [DATA_WIDTH-1:0]   isp_data_next;
    logic                    accept;
    logic                    asm_clear;
    logic                    asm_valid;
    logic [DATA_WIDTH-1:0]   asm_word_c;
    logic                    asm_ready_c;
    logic [7:0]              xor_sum;

    assign accept       = in_valid && in_ready;
    assign asm_valid    = accept && (state == DATA);
    assign n_c          = {in_data, len[7:0]};
    assign prog_address = '0;

    isp_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clock        (clock),
        .reset        (reset),
        .clear        (asm_clear),
        .byte_valid   (asm_valid),
        .byte_in      (in_data),
        .word_c       (asm_word_c),
        .word_ready_c (asm_ready_c),
        .xor_sum      (xor_sum)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_next       = state;
        len_next         = len;
        word_addr_next   = word_addr;
        tcount_next      = tcount;
        words_next       = words_loaded;
        write_next       = 1'b0;
        isp_address_next = isp_address;
        isp_data_next    = isp_data;
        asm_clear        = 1'b0;

        case (state)
            IDLE, DONE, ERROR: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_next     = LEN_LO;
                    asm_clear      = 1'b1;
                    words_next     = '0;
                    word_addr_next = '0;
                    tcount_next    = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_next   = {len[15:8], in_data};
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_next = n_c;
                    if ((n_c == '0) || (32'(n_c) > MAX_WORDS)) state_next = ERROR;
                    else                                       state_next = DATA;
                end
            end
            DATA: begin
                if (asm_ready_c) begin
                    write_next       = 1'b1;
                    isp_data_next    = asm_word_c;
                    isp_address_next = word_addr;
                    word_addr_next   = word_addr + ADDRESS_BITS'(1);
                    words_next       = words_loaded + LEN_BITS'(1);
                    if (words_next == len) state_next = CSUM;
                end
            end
            CSUM: begin
                if (accept) state_next = (in_data == xor_sum) ? START : ERROR;
            end
            START:   state_next = DONE;
            default: state_next = ERROR;
        endcase

        // Inter-byte watchdog; the partial image is left in memory.
        if (in_frame(state)) begin
            if (accept) begin
                tcount_next = '0;
            end else begin
                tcount_next = tcount + TW'(1);
                if (tcount_next == TW'(TIMEOUT_CYCLES)) state_next = ERROR;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            len          <= '0;
            word_addr    <= '0;
            tcount       <= '0;
            in_ready     <= 1'b1;
            isp_write    <= 1'b0;
            isp_address  <= '0;
            isp_data     <= '0;
            core_reset   <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_next;
            len          <= len_next;
            word_addr    <= word_addr_next;
            tcount       <= tcount_next;
            in_ready     <= (state_next != START);
            isp_write    <= write_next;
            isp_address  <= isp_address_next;
            isp_data     <= isp_data_next;
            core_reset   <= in_frame(state_next);
            start        <= (state_next == START);
            busy         <= in_frame(state_next) || (state_next == START);
            error        <= (state_next == ERROR);
            words_loaded <= words_next;
        end
    end

endmodule

// File: tb/tb_isp_program_loader.sv
// Directed self-checking bench for isp_program_loader.
module tb_isp_program_loader;
    import isp_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        isp_write;
    logic [11:0] isp_address;
    logic [31:0] isp_data;
    logic        core_reset;
    logic        start;
    logic [19:0] prog_address;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cnt = 0;
    int          start_cnt = 0;
    logic [19:0] start_pa = 20'hFFFFF;
    logic        start_cr = 1'b1;
    logic        start_ir = 1'b1;
    int          base;
    int          sbase;

    logic [7:0] frame_a [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                 8'h93, 8'h05, 8'h30, 8'h00, 8'hA0};

    isp_program_loader dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .isp_write    (isp_write),
        .isp_address  (isp_address),
        .isp_data     (isp_data),
        .core_reset   (core_reset),
        .start        (start),
        .prog_address (prog_address),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    // Record every write strobe and start pulse.
    always @(negedge clock) begin
        if (isp_write) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = isp_address;
                wr_data[wr_cnt] = isp_data;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (start) begin
            start_cnt = start_cnt + 1;
            start_pa  = prog_address;
            start_cr  = core_reset;
            start_ir  = in_ready;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 8) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_wr"},    32'(isp_write), 32'd0);
        check({tag, "_addr"},  32'(isp_address), 32'd0);
        check({tag, "_data"},  isp_data, 32'd0);
        check({tag, "_crst"},  32'(core_reset), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_err"},   32'(error), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    task automatic good_frame(input string tag);
        base  = wr_cnt;
        sbase = start_cnt;
        for (int i = 0; i < 12; i++) send(frame_a[i]);
        idle(3);
        check({tag, "_nwr"},   32'(wr_cnt - base), 32'd2);
        check({tag, "_a0"},    32'(wr_addr[base]), 32'd0);
        check({tag, "_d0"},    wr_data[base], 32'h00100513);
        check({tag, "_a1"},    32'(wr_addr[base+1]), 32'd1);
        check({tag, "_d1"},    wr_data[base+1], 32'h00300593);
        check({tag, "_start"}, 32'(start_cnt - sbase), 32'd1);
        check({tag, "_pa"},    32'(start_pa), 32'd0);
        check({tag, "_st_cr"}, 32'(start_cr), 32'd0);
        check({tag, "_st_ir"}, 32'(start_ir), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd2);
        check({tag, "_err"},   32'(error), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'(DONE));
    endtask

    initial begin
        idle(3);
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b0;

        // Good frame, checking strobe latency and core_reset on the way.
        base  = wr_cnt;
        sbase = start_cnt;
        send(8'hA5);
        @(negedge clock);
        check("a_crst_sync", 32'(core_reset), 32'd1);
        check("a_busy_sync", 32'(busy), 32'd1);
        for (int i = 1; i < 7; i++) send(frame_a[i]);
        @(negedge clock);
        check("a_wr_lat",  32'(isp_write), 32'd1);
        check("a_wr_data", isp_data, 32'h00100513);
        check("a_wl_same", 32'(words_loaded), 32'd1);
        for (int i = 7; i < 11; i++) send(frame_a[i]);
        @(negedge clock);
        check("a_crst_csum", 32'(core_reset), 32'd1);
        send(frame_a[11]);
        idle(3);
        check("a_nwr",   32'(wr_cnt - base), 32'd2);
        check("a_a1",    32'(wr_addr[base+1]), 32'd1);
        check("a_d1",    wr_data[base+1], 32'h00300593);
        check("a_start", 32'(start_cnt - sbase), 32'd1);
        check("a_pa",    32'(start_pa), 32'd0);
        check("a_st_cr", 32'(start_cr), 32'd0);
        check("a_words", 32'(words_loaded), 32'd2);
        check("a_err",   32'(error), 32'd0);
        check("a_crst",  32'(core_reset), 32'd0);

        // Bad checksum.
        base  = wr_cnt;
        sbase = start_cnt;
        for (int i = 0; i < 11; i++) send(frame_a[i]);
        send(8'h00);
        idle(3);
        check("bad_nwr",   32'(wr_cnt - base), 32'd2);
        check("bad_start", 32'(start_cnt - sbase), 32'd0);
        check("bad_err",   32'(error), 32'd1);
        check("bad_crst",  32'(core_reset), 32'd0);
        check("bad_state", 32'(dut.state), 32'(ERROR));
        send(8'hA5);
        @(negedge clock);
        check("bad_err_clr", 32'(error), 32'd0);
        for (int i = 1; i < 12; i++) send(frame_a[i]);
        idle(3);
        check("rec_start", 32'(start_cnt - sbase), 32'd1);
        check("rec_err",   32'(error), 32'd0);

        // Length bounds.
        base = wr_cnt;
        send(8'hA5); send(8'h01); send(8'h10);
        idle(2);
        check("n4097_err", 32'(error), 32'd1);
        check("n4097_nwr", 32'(wr_cnt - base), 32'd0);
        send(8'hA5); send(8'h00); send(8'h10);
        idle(2);
        check("n4096_state", 32'(dut.state), 32'(DATA));
        check("n4096_err",   32'(error), 32'd0);

        // Stall mid-word until the watchdog fires.
        send(8'h11); send(8'h22);
        idle(1000);
        check("to_busy_early", 32'(busy), 32'd1);
        idle(40);
        check("to_err",  32'(error), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_nwr",  32'(wr_cnt - base), 32'd0);

        send(8'hA5); send(8'h00); send(8'h00);
        idle(2);
        check("n0_err", 32'(error), 32'd1);

        // Garbage before sync, sync byte inside payload.
        base  = wr_cnt;
        sbase = start_cnt;
        send(8'h00); send(8'hFF); send(8'h5A);
        @(negedge clock);
        check("garb_busy", 32'(busy), 32'd0);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hA5); send(8'h11); send(8'h22); send(8'h33);
        send(8'hA5);
        idle(3);
        check("pay_nwr",   32'(wr_cnt - base), 32'd1);
        check("pay_d0",    wr_data[base], 32'h332211A5);
        check("pay_start", 32'(start_cnt - sbase), 32'd1);
        check("pay_words", 32'(words_loaded), 32'd1);

        // Asynchronous reset during DATA after one word.
        base = wr_cnt;
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_reset_values("mid");
        idle(2);
        reset = 1'b0;
        send(8'h06); send(8'h07); send(8'h08);
        idle(3);
        check("mid_nwr",  32'(wr_cnt - base), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);

        good_frame("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got %0d expected %0d", 0, 1);
        $fatal(1);
    end

endmodule
